fft_ram_arbiter: RTL and testbench
==================================

# fft_ram_arbiter

Round-robin controller that shares the single-port FFT sample RAM between N_REQ requesters (butterfly engine, host loader, output unloader). It serialises their read/write requests onto the RAM's read_write/address/tri-state data bus and sequences the RAM's reset. It owns every RAM pin, so it is the only driver of the shared data bus.

## Interface
Parameters:
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 8, RAM address width
- N_REQ, 2, number of requesters (2..8)

Ports:
- clk  in  1  system clock, rising-edge
- bus_clr  in  1  reset, asynchronous, active-high
- req  in  N_REQ  per-requester access request; held high until gnt is seen
- req_we  in  N_REQ  per-requester access type: 1=write, 0=read
- req_addr  in  N_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i
- req_wdata  in  N_REQ*DATA_WIDTH  packed write data; requester i uses slice i
- gnt  out  N_REQ  one-hot grant pulse, one cycle long
- rvalid  out  N_REQ  one-hot read-data-valid pulse, one cycle long
- rdata  out  DATA_WIDTH  last read word, shared by all requesters
- busy  out  1  high in any state other than IDLE, and while ram_reset is high
- ram_reset  out  1  RAM reset
- ram_read_write  out  1  RAM access type: 1=write, 0=read
- ram_address  out  ADDR_WIDTH  RAM address
- ram_data  inout  DATA_WIDTH  RAM data bus; driven only during a write ACCESS, otherwise 'z

## Operation
- States: INIT, IDLE, ACCESS, CAPTURE, RECOVER.
- INIT: entered on reset. ram_reset stays high while bus_clr is high and for 2 clk edges after bus_clr deasserts. Then go to IDLE. No grants are issued in INIT.
- IDLE, when some req bit is high:
  - rr_arbiter picks a winner w, starting its search at pointer ptr.
  - On the clock edge: latch req_addr[w], req_wdata[w] and req_we[w]; set ptr = (w+1) mod N_REQ; go to ACCESS.
  - Requests are sampled only at this edge.
- ACCESS:
  - gnt[w]=1.
  - ram_address = latched address.
  - ram_read_write = latched we.
  - If we=1, ram_data is driven with the latched data.
  - Next state is RECOVER if we=1, CAPTURE if we=0.
  - The requester may drop or change req at the edge that ends the gnt cycle.
- CAPTURE:
  - ram_read_write=0, ram_address is held, ram_data is undriven.
  - At the edge ending CAPTURE, ram_data is sampled into rdata.
  - rvalid[w]=1 for the next (IDLE) cycle. Go to IDLE.
- RECOVER: bus turnaround. ram_read_write=0, ram_data undriven. Go to IDLE.
- Round-robin: ptr=0 after reset. A requester that holds req continuously is granted within N_REQ transactions.
- Requester outputs are ignored outside the IDLE sampling edge.

## Timing
- Reset values: gnt=0, rvalid=0, rdata=0, busy=1, ram_reset=1, ram_read_write=0, ram_address=0, ram_data='z, ptr=0, state=INIT.
- Reset asserted mid-transaction: the bus is released asynchronously. No gnt or rvalid is issued for the aborted access.
- Every transaction takes 3 cycles, giving a peak of one access per 3 clk.
- Relative to the IDLE sampling edge at T0 (gnt rises at T0):
  - Write: gnt at T0..T1, RAM write cycle T0..T1.
  - Read: rdata and rvalid valid at T2..T3.
- ram_data is never driven in CAPTURE, RECOVER, IDLE or INIT. The arbiter and the RAM are therefore never drivers in the same cycle.
- Simultaneous requests: exactly one grant per transaction. The other requests wait with req held.
- A req that rises during a non-IDLE state waits for the next IDLE edge.
- Back-to-back: rvalid of a read and the arbitration of the next request share the same IDLE cycle.

## Structure
- Shared package `mine` holds:
  - typedef enum arb_state_t {INIT, IDLE, ACCESS, CAPTURE, RECOVER}
  - constants RAM_WRITE=1'b1, RAM_READ=1'b0
  - constant RAM_RESET_HOLD=2
- Sub-module `rr_arbiter`:
  - parameter N_REQ; inputs req and ptr.
  - Outputs one-hot winner, encoded index and any_req.
  - Combinational; ptr is kept in the parent.

## Test plan
- Reset: hold bus_clr 3 cycles, then release. ram_reset falls exactly 2 edges later, ram_data is 'z throughout, and no gnt is issued while ram_reset is high.
- Single write: req0 with we=1, addr 8'h12, data 16'hBEEF. gnt[0] pulses once, ram_read_write=1 and ram_data=16'hBEEF for one cycle, then the bus is 'z.
- Read-back: req1 with we=0, addr 8'h12. rvalid[1] pulses 2 cycles after gnt[1], rdata=16'hBEEF.
- Contention:
  - req0 and req1 held high for 4 transactions after reset.
  - Grant order is 0,1,0,1.
  - Exactly one gnt bit is high in any cycle.
- Mid-access reset: assert bus_clr during a write ACCESS. ram_data goes 'z the same cycle, no rvalid follows, state returns to INIT, and ptr resets to 0.
- Bus-contention monitor: random traffic, 200 transactions. The arbiter drives ram_data only when ram_read_write=1, and a scoreboard matches every read.

Source files
------------

// File: rtl/fft_ram_arbiter_pkg.sv
// Shared definitions for the FFT sample-RAM arbiter.
//   arb_state_t    : arbiter sequencing states
//   RAM_WRITE/READ : encoding of the RAM read_write pin
//   RAM_RESET_HOLD : clk edges ram_reset stays high after bus_clr drops
package mine;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ACCESS,
        CAPTURE,
        RECOVER
    } arb_state_t;

    localparam logic RAM_WRITE = 1'b1;
    localparam logic RAM_READ  = 1'b0;

    localparam int RAM_RESET_HOLD = 2;

endpackage

// File: rtl/fft_ram_arbiter_if.sv
// Requester-side bus of the FFT sample-RAM arbiter.
//   req/req_we/req_addr/req_wdata : per-requester requests, slice i = requester i
//   gnt/rvalid                    : one-hot single-cycle pulses back to requesters
//   rdata                         : last read word, shared by all requesters
// master = requester side, slave = arbiter side.
interface fft_ram_arbiter_if #(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0]            req_we;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]            gnt;
    logic [N_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]       rdata;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/fft_ram_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index where the search starts (highest priority this round)
//   winner  : one-hot winner, zero when no request
//   win_idx : encoded winner index
//   any_req : at least one request is pending
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_req
);
    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        any_req = |req;
        // Walk the ring starting at ptr; the first requester hit wins.
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found         = 1'b1;
                winner[cand]  = 1'b1;
                win_idx       = cand;
            end
        end
    end
endmodule

// File: rtl/fft_ram_arbiter.sv
// Round-robin owner of the single-port FFT sample RAM.
//   clk            : system clock, rising edge
//   bus_clr        : asynchronous active-high reset
//   arb_bus        : requester bus (req/req_we/req_addr/req_wdata in, gnt/rvalid/rdata out)
//   busy           : high whenever not IDLE (includes the RAM reset sequence)
//   ram_reset      : RAM reset, held RAM_RESET_HOLD edges past bus_clr release
//   ram_read_write : 1 = write, 0 = read
//   ram_address    : RAM address of the current/last access
//   ram_data       : tri-state data bus, driven only during a write ACCESS
// One access per 3 clk: IDLE(sample) -> ACCESS -> CAPTURE (read) / RECOVER (write).
module fft_ram_arbiter
    import mine::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int N_REQ      = 2
) (
    input  logic                  clk,
    input  logic                  bus_clr,
    fft_ram_arbiter_if.slave      arb_bus,
    output logic                  busy,
    output logic                  ram_reset,
    output logic                  ram_read_write,
    output logic [ADDR_WIDTH-1:0] ram_address,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t            state_reg;
    logic [1:0]            hold_cnt_reg;
    logic [IDX_W-1:0]      ptr_reg;
    logic [IDX_W-1:0]      ptr_next;
    logic [N_REQ-1:0]      grant_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  we_reg;
    logic [N_REQ-1:0]      rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  ram_drive;

    logic [N_REQ-1:0]      win_onehot;
    logic [IDX_W-1:0]      win_idx;
    logic                  any_req;

    logic [ADDR_WIDTH-1:0] addr_arr  [N_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [N_REQ];

    // Unpack the flat request buses so the winner can be indexed directly.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = arb_bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = arb_bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (arb_bus.req),
        .ptr     (ptr_reg),
        .winner  (win_onehot),
        .win_idx (win_idx),
        .any_req (any_req)
    );

    assign ptr_next = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk or posedge bus_clr) begin
        if (bus_clr) begin
            state_reg    <= INIT;
            hold_cnt_reg <= '0;
            ptr_reg      <= '0;
            grant_reg    <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            we_reg       <= RAM_READ;
            rvalid_reg   <= '0;
            rdata_reg    <= '0;
        end else begin
            rvalid_reg <= '0;
            case (state_reg)
                INIT: begin
                    if (hold_cnt_reg == 2'(RAM_RESET_HOLD - 1)) begin
                        state_reg <= IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 2'd1;
                    end
                end
                IDLE: begin
                    // Only edge where requester inputs are looked at.
                    if (any_req) begin
                        grant_reg <= win_onehot;
                        addr_reg  <= addr_arr[win_idx];
                        wdata_reg <= wdata_arr[win_idx];
                        we_reg    <= arb_bus.req_we[win_idx];
                        ptr_reg   <= ptr_next;
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    state_reg <= (we_reg == RAM_WRITE) ? RECOVER : CAPTURE;
                end
                CAPTURE: begin
                    rdata_reg  <= ram_data;
                    rvalid_reg <= grant_reg;
                    state_reg  <= IDLE;
                end
                RECOVER: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= INIT;
                end
            endcase
        end
    end

    // Outputs decode directly from state so bus_clr releases the bus
    // without waiting for a clock edge.
    assign ram_drive      = (state_reg == ACCESS) && (we_reg == RAM_WRITE);
    assign ram_data       = ram_drive ? wdata_reg : 'z;
    assign ram_read_write = ram_drive;
    assign ram_address    = addr_reg;
    assign ram_reset      = (state_reg == INIT);
    assign busy           = (state_reg != IDLE) || ram_reset;

    assign arb_bus.gnt    = (state_reg == ACCESS) ? grant_reg : '0;
    assign arb_bus.rvalid = rvalid_reg;
    assign arb_bus.rdata  = rdata_reg;

endmodule

// File: tb/tb_fft_ram_arbiter.sv
// Scoreboard bench for fft_ram_arbiter: stimulus pushes expected grants and
// read results into queues; a negedge monitor pops and compares whenever the
// DUT pulses gnt or rvalid, and also watches bus ownership every cycle.
module tb_fft_ram_arbiter;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int NR = 2;

    typedef struct {
        int           idx;
        bit           we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } gnt_exp_t;

    typedef struct {
        int           idx;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          bus_clr;
    logic          busy;
    logic          ram_reset;
    logic          ram_read_write;
    logic [AW-1:0] ram_address;
    wire  [DW-1:0] ram_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    gnt_exp_t exp_gnt[$];
    rd_exp_t  exp_rd[$];
    int       rd_gnt_cyc[$];

    fft_ram_arbiter_if #(.N_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) arb_bus ();

    fft_ram_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .N_REQ      (NR)
    ) dut (
        .clk            (clk),
        .bus_clr        (bus_clr),
        .arb_bus        (arb_bus),
        .busy           (busy),
        .ram_reset      (ram_reset),
        .ram_read_write (ram_read_write),
        .ram_address    (ram_address),
        .ram_data       (ram_data)
    );

    always #5 clk = ~clk;

    // RAM model: writes on the edge ending a write cycle; drives read data
    // through the cycle after a read ACCESS.
    logic [DW-1:0] mem [256] = '{default: '0};
    logic          rd_phase  = 1'b0;

    always @(posedge clk) begin
        rd_phase <= (arb_bus.gnt != 0) && !ram_read_write && !ram_reset;
        if (!ram_reset && ram_read_write) mem[ram_address] <= ram_data;
    end

    assign ram_data = (rd_phase && !ram_reset) ? mem[ram_address] : 'z;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        gnt_exp_t g;
        rd_exp_t  r;
        int       gc;
        cyc++;
        if (ram_reset) chk("gnt_in_reset", 32'(arb_bus.gnt), 32'd0);
        if (!ram_read_write && !(rd_phase && !ram_reset))
            chk("bus_float", 32'(ram_data === 16'bz), 32'd1);
        if (arb_bus.gnt != 0) begin
            chk("gnt_onehot", $countones(arb_bus.gnt), 32'd1);
            if (exp_gnt.size() == 0) begin
                chk("gnt_unexpected", 32'(arb_bus.gnt), 32'd0);
            end else begin
                g = exp_gnt.pop_front();
                $display("txn gnt req%0d we=%0d addr=%h data=%h", g.idx, g.we, g.addr, g.data);
                chk("gnt_idx", 32'(arb_bus.gnt), 32'(1 << g.idx));
                chk("gnt_rw", 32'(ram_read_write), 32'(g.we));
                chk("gnt_addr", 32'(ram_address), 32'(g.addr));
                if (g.we) chk("wr_data", 32'(ram_data), 32'(g.data));
                else rd_gnt_cyc.push_back(cyc);
            end
        end
        if (arb_bus.rvalid != 0) begin
            if (exp_rd.size() == 0 || rd_gnt_cyc.size() == 0) begin
                chk("rvalid_unexpected", 32'(arb_bus.rvalid), 32'd0);
            end else begin
                r  = exp_rd.pop_front();
                gc = rd_gnt_cyc.pop_front();
                $display("txn rvalid req%0d rdata=%h", r.idx, arb_bus.rdata);
                chk("rvalid_idx", 32'(arb_bus.rvalid), 32'(1 << r.idx));
                chk("rdata", 32'(arb_bus.rdata), 32'(r.data));
                chk("rd_latency", 32'(cyc - gc), 32'd2);
            end
        end
    end

    task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        arb_bus.req_we[i]          = we;
        arb_bus.req_addr[i*AW +: AW]  = a;
        arb_bus.req_wdata[i*DW +: DW] = d;
        arb_bus.req[i]             = 1'b1;
    endtask

    task automatic push_gnt(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        gnt_exp_t g;
        g.idx = i; g.we = we; g.addr = a; g.data = d;
        exp_gnt.push_back(g);
    endtask

    task automatic push_rd(input int i, input logic [DW-1:0] d);
        rd_exp_t r;
        r.idx = i; r.data = d;
        exp_rd.push_back(r);
    endtask

    task automatic wait_gnt(input int i);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (arb_bus.gnt[i]) return;
        end
        chk("gnt_timeout", 32'd0, 32'(i + 1));
    endtask

    logic [DW-1:0] shadow [8] = '{default: '0};

    initial begin
        int            ri;
        bit            rwe;
        logic [2:0]    ra;
        logic [DW-1:0] rdv;

        bus_clr           = 1'b1;
        arb_bus.req       = '0;
        arb_bus.req_we    = '0;
        arb_bus.req_addr  = '0;
        arb_bus.req_wdata = '0;

        // Reset with a write request already pending: it must not be granted
        // before the RAM reset sequence completes.
        set_req(0, 1'b1, 8'h12, 16'hBEEF);
        push_gnt(0, 1'b1, 8'h12, 16'hBEEF);
        repeat (3) begin
            @(negedge clk);
            chk("rst_ram_reset", 32'(ram_reset), 32'd1);
            chk("rst_busy", 32'(busy), 32'd1);
            chk("rst_rvalid", 32'(arb_bus.rvalid), 32'd0);
            chk("rst_rdata", 32'(arb_bus.rdata), 32'd0);
            chk("rst_rw", 32'(ram_read_write), 32'd0);
            chk("rst_addr", 32'(ram_address), 32'd0);
        end
        bus_clr = 1'b0;
        @(negedge clk);
        chk("ram_reset_edge1", 32'(ram_reset), 32'd1);
        @(negedge clk);
        chk("ram_reset_edge2", 32'(ram_reset), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single write
        wait_gnt(0);
        arb_bus.req[0] = 1'b0;

        // Read-back on requester 1
        set_req(1, 1'b0, 8'h12, 16'h0000);
        push_gnt(1, 1'b0, 8'h12, 16'h0000);
        push_rd(1, 16'hBEEF);
        wait_gnt(1);
        arb_bus.req[1] = 1'b0;

        // Contention: both held for 4 transactions, order 0,1,0,1
        set_req(0, 1'b1, 8'h40, 16'hA000);
        set_req(1, 1'b1, 8'h50, 16'hB000);
        push_gnt(0, 1'b1, 8'h40, 16'hA000);
        push_gnt(1, 1'b1, 8'h50, 16'hB000);
        push_gnt(0, 1'b1, 8'h41, 16'hA001);
        push_gnt(1, 1'b1, 8'h51, 16'hB001);
        wait_gnt(0); set_req(0, 1'b1, 8'h41, 16'hA001);
        wait_gnt(1); set_req(1, 1'b1, 8'h51, 16'hB001);
        wait_gnt(0); arb_bus.req[0] = 1'b0;
        wait_gnt(1); arb_bus.req[1] = 1'b0;

        // Mid-access reset during a write (ptr is 1 after this grant)
        set_req(0, 1'b1, 8'h60, 16'h1234);
        push_gnt(0, 1'b1, 8'h60, 16'h1234);
        wait_gnt(0);
        arb_bus.req = '0;
        #1 bus_clr = 1'b1;
        #1;
        chk("abort_bus_z", 32'(ram_data === 16'bz), 32'd1);
        chk("abort_gnt", 32'(arb_bus.gnt), 32'd0);
        chk("abort_rw", 32'(ram_read_write), 32'd0);
        chk("abort_ram_reset", 32'(ram_reset), 32'd1);
        chk("abort_busy", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        bus_clr = 1'b0;

        // Simultaneous reads after reset: ptr back at 0, so req0 first.
        // Address 8'h60 was never written (aborted access).
        set_req(0, 1'b0, 8'h40, 16'h0000);
        set_req(1, 1'b0, 8'h60, 16'h0000);
        push_gnt(0, 1'b0, 8'h40, 16'h0000);
        push_rd(0, 16'hA000);
        push_gnt(1, 1'b0, 8'h60, 16'h0000);
        push_rd(1, 16'h0000);
        wait_gnt(0); arb_bus.req[0] = 1'b0;
        wait_gnt(1); arb_bus.req[1] = 1'b0;

        // Random back-to-back traffic, one requester at a time
        for (int t = 0; t < 200; t++) begin
            ri  = $urandom_range(0, NR - 1);
            rwe = 1'($urandom_range(0, 1));
            ra  = 3'($urandom_range(0, 7));
            rdv = 16'($urandom);
            arb_bus.req = '0;
            set_req(ri, rwe, {5'b11000, ra}, rdv);
            push_gnt(ri, rwe, {5'b11000, ra}, rdv);
            if (rwe) shadow[ra] = rdv;
            else push_rd(ri, shadow[ra]);
            wait_gnt(ri);
        end
        arb_bus.req = '0;

        repeat (6) @(negedge clk);
        chk("gnt_queue_drained", 32'(exp_gnt.size()), 32'd0);
        chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
